// File: rtl/music_tone_gen.sv
// music_tone_gen: turns the player's is_playing/song outputs into a square-wave
// tone by walking a 4-song x 8-step note ROM. Each step lasts TICK_DIV*NOTE_TICKS
// cycles. Note code c (1..7) has half-period BASE_HALF*(9-c) cycles; code 0 is a
// rest.
// Build option: define TONE_LOOP_EN to make the song loop from step 7 back to
// step 0. Without it, the song stops in DONE after step 7.
module music_tone_gen #(
    parameter int TICK_DIV   = 50000,
    parameter int NOTE_TICKS = 100,
    parameter int BASE_HALF  = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       is_playing,
    input  logic [1:0] song,
    output logic       audio_out,
    output logic [2:0] note_code,
    output logic [2:0] step,
    output logic       step_strobe,
    output logic [1:0] dbg_state_o
);

    // Each counter is just wide enough for its largest value.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam int HW = $clog2(BASE_HALF * 8);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DUR_MAX   = DW'(NOTE_TICKS - 1);

    // Note ROM, indexed [song][step].
    localparam logic [2:0] ROM [4][8] = '{
        '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0},
        '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
        '{3'd1, 3'd3, 3'd5, 3'd7, 3'd5, 3'd3, 3'd1, 3'd0},
        '{3'd4, 3'd4, 3'd0, 3'd4, 3'd4, 3'd0, 3'd7, 3'd0}
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    song_q, song_d;
    logic [2:0]    step_q, step_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dur_q, dur_d;
    logic [HW-1:0] half_q, half_d;
    logic          phase_q, phase_d;
    logic          audio_q, audio_d;
    logic          strobe_q, strobe_d;
    logic [HW-1:0] half_max;

    assign note_code   = ROM[song_q][step_q];
    assign step        = step_q;
    assign audio_out   = audio_q;
    assign step_strobe = strobe_q;
    assign dbg_state_o = state_q;

    // Next-state logic: song change first, then per-state sequencing.
    always_comb begin
        state_d  = state_q;
        song_d   = song_q;
        step_d   = step_q;
        presc_d  = presc_q;
        dur_d    = dur_q;
        half_d   = half_q;
        phase_d  = phase_q;
        strobe_d = 1'b0;
        half_max = HW'(BASE_HALF * (9 - int'(note_code)) - 1);

        if (song != song_q) begin
            // A new song restarts the position; state keeps its play/pause sense.
            song_d  = song;
            step_d  = 3'd0;
            presc_d = '0;
            dur_d   = '0;
            half_d  = '0;
            phase_d = 1'b0;
            case (state_q)
                RUN: begin
                    if (is_playing) strobe_d = 1'b1;
                    else            state_d  = HOLD;
                end
                DONE: begin
                    if (is_playing) begin
                        state_d  = RUN;
                        strobe_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_playing) begin
                        state_d  = RUN;
                        strobe_d = 1'b1;
                    end
                end
                RUN: begin
                    if (!is_playing) begin
                        // Pause freezes everything, even a step end due this cycle.
                        state_d = HOLD;
                    end else begin
                        if (note_code != 3'd0) begin
                            if (half_q == half_max) begin
                                half_d  = '0;
                                phase_d = ~phase_q;
                            end else begin
                                half_d = half_q + 1'b1;
                            end
                        end else begin
                            phase_d = 1'b0;
                        end
                        if (presc_q == PRESC_MAX) begin
                            presc_d = '0;
                            if (dur_q == DUR_MAX) begin
                                dur_d   = '0;
                                half_d  = '0;
                                phase_d = 1'b0;
                                if (step_q == 3'd7) begin
`ifdef TONE_LOOP_EN
                                    step_d   = 3'd0;
                                    strobe_d = 1'b1;
`else
                                    state_d = DONE;
`endif
                                end else begin
                                    step_d   = step_q + 3'd1;
                                    strobe_d = 1'b1;
                                end
                            end else begin
                                dur_d = dur_q + 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (is_playing) state_d = RUN;
                end
                DONE: begin
                    if (!is_playing) begin
                        state_d = IDLE;
                        step_d  = 3'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Audio follows the phase only while the next cycle is a RUN cycle.
        audio_d = (state_d == RUN) & phase_d;
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            song_q   <= 2'd0;
            step_q   <= 3'd0;
            presc_q  <= '0;
            dur_q    <= '0;
            half_q   <= '0;
            phase_q  <= 1'b0;
            audio_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            song_q   <= song_d;
            step_q   <= step_d;
            presc_q  <= presc_d;
            dur_q    <= dur_d;
            half_q   <= half_d;
            phase_q  <= phase_d;
            audio_q  <= audio_d;
            strobe_q <= strobe_d;
        end
    end

endmodule

// File: tb/tb_music_tone_gen.sv
// Bench for music_tone_gen with TICK_DIV=10, NOTE_TICKS=4, BASE_HALF=1
// (step = 40 cycles, half-period of note c = 9-c cycles).
module tb_music_tone_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       is_playing;
    logic [1:0] song;
    logic       audio_out;
    logic [2:0] note_code;
    logic [2:0] step;
    logic       step_strobe;
    logic [1:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    music_tone_gen #(.TICK_DIV(10), .NOTE_TICKS(4), .BASE_HALF(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .is_playing  (is_playing),
        .song        (song),
        .audio_out   (audio_out),
        .note_code   (note_code),
        .step        (step),
        .step_strobe (step_strobe),
        .dbg_state_o (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic       play;
        logic [1:0] sng;
        int         adv;
        logic       audio;
        logic [2:0] stp;
        logic [2:0] note;
        logic       strobe;
    } vec_t;

    vec_t vecs [27];

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic e_audio, input logic [2:0] e_step,
                       input logic [2:0] e_note, input logic e_strobe);
        n_vec++;
        if ({audio_out, step, note_code, step_strobe} !== {e_audio, e_step, e_note, e_strobe}) begin
            n_err++;
            $display("FAIL %s: got audio=%b step=%0d note=%0d strobe=%b, want audio=%b step=%0d note=%0d strobe=%b",
                     name, audio_out, step, note_code, step_strobe, e_audio, e_step, e_note, e_strobe);
        end
    endtask

    task automatic chk_state(input string name, input logic [1:0] e_state);
        n_vec++;
        if (dbg_state !== e_state) begin
            n_err++;
            $display("FAIL %s: got state=%0d, want state=%0d", name, dbg_state, e_state);
        end
    endtask

    initial begin
        // Main song0 walk, pause/resume in step 2, song change to song3 in step 5.
        vecs[0]  = '{1'b1, 2'd0, 1,  1'b0, 3'd0, 3'd1, 1'b1};
        vecs[1]  = '{1'b1, 2'd0, 1,  1'b0, 3'd0, 3'd1, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 6,  1'b0, 3'd0, 3'd1, 1'b0};
        vecs[3]  = '{1'b1, 2'd0, 1,  1'b1, 3'd0, 3'd1, 1'b0};
        vecs[4]  = '{1'b1, 2'd0, 7,  1'b1, 3'd0, 3'd1, 1'b0};
        vecs[5]  = '{1'b1, 2'd0, 1,  1'b0, 3'd0, 3'd1, 1'b0};
        vecs[6]  = '{1'b1, 2'd0, 8,  1'b1, 3'd0, 3'd1, 1'b0};
        vecs[7]  = '{1'b1, 2'd0, 15, 1'b0, 3'd0, 3'd1, 1'b0};
        vecs[8]  = '{1'b1, 2'd0, 1,  1'b0, 3'd1, 3'd2, 1'b1};
        vecs[9]  = '{1'b1, 2'd0, 6,  1'b0, 3'd1, 3'd2, 1'b0};
        vecs[10] = '{1'b1, 2'd0, 1,  1'b1, 3'd1, 3'd2, 1'b0};
        vecs[11] = '{1'b1, 2'd0, 7,  1'b0, 3'd1, 3'd2, 1'b0};
        vecs[12] = '{1'b1, 2'd0, 26, 1'b0, 3'd2, 3'd3, 1'b1};
        vecs[13] = '{1'b1, 2'd0, 15, 1'b0, 3'd2, 3'd3, 1'b0};
        vecs[14] = '{1'b0, 2'd0, 1,  1'b0, 3'd2, 3'd3, 1'b0};
        vecs[15] = '{1'b0, 2'd0, 99, 1'b0, 3'd2, 3'd3, 1'b0};
        vecs[16] = '{1'b1, 2'd0, 1,  1'b0, 3'd2, 3'd3, 1'b0};
        vecs[17] = '{1'b1, 2'd0, 3,  1'b1, 3'd2, 3'd3, 1'b0};
        vecs[18] = '{1'b1, 2'd0, 21, 1'b0, 3'd2, 3'd3, 1'b0};
        vecs[19] = '{1'b1, 2'd0, 1,  1'b0, 3'd3, 3'd4, 1'b1};
        vecs[20] = '{1'b1, 2'd0, 40, 1'b0, 3'd4, 3'd5, 1'b1};
        vecs[21] = '{1'b1, 2'd0, 40, 1'b0, 3'd5, 3'd6, 1'b1};
        vecs[22] = '{1'b1, 2'd0, 10, 1'b1, 3'd5, 3'd6, 1'b0};
        vecs[23] = '{1'b1, 2'd3, 1,  1'b0, 3'd0, 3'd4, 1'b1};
        vecs[24] = '{1'b1, 2'd3, 5,  1'b1, 3'd0, 3'd4, 1'b0};
        vecs[25] = '{1'b1, 2'd3, 35, 1'b0, 3'd1, 3'd4, 1'b1};
        vecs[26] = '{1'b1, 2'd3, 40, 1'b0, 3'd2, 3'd0, 1'b1};

        // Reset
        rst        = 1'b0;
        is_playing = 1'b0;
        song       = 2'd0;
        tick(3);
        chk("reset", 1'b0, 3'd0, 3'd1, 1'b0);
        chk_state("reset_state", S_IDLE);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(25);
            chk($sformatf("idle_hold_%0d", i), 1'b0, 3'd0, 3'd1, 1'b0);
        end
        chk_state("idle_state", S_IDLE);

        // Song change while idle only updates the selected song.
        song = 2'd1;
        tick(1);
        chk("idle_song1", 1'b0, 3'd0, 3'd7, 1'b0);
        chk_state("idle_song1_state", S_IDLE);
        song = 2'd0;
        tick(1);
        chk("idle_song0", 1'b0, 3'd0, 3'd1, 1'b0);

        // Table vectors
        for (int i = 0; i < 27; i++) begin
            is_playing = vecs[i].play;
            song       = vecs[i].sng;
            tick(vecs[i].adv);
            chk($sformatf("vec_%0d", i), vecs[i].audio, vecs[i].stp, vecs[i].note, vecs[i].strobe);
        end
        chk_state("after_table", S_RUN);

        // Rest step of song3 stays silent for its whole length.
        for (int i = 1; i < 40; i++) begin
            tick(1);
            chk($sformatf("rest_%0d", i), 1'b0, 3'd2, 3'd0, 1'b0);
        end
        tick(1);
        chk("rest_end", 1'b0, 3'd3, 3'd4, 1'b1);

        // Song change while paused: position clears, no strobe, stays paused.
        is_playing = 1'b0;
        tick(1);
        chk_state("pause2_state", S_HOLD);
        song = 2'd0;
        tick(1);
        chk("hold_song_change", 1'b0, 3'd0, 3'd1, 1'b0);
        chk_state("hold_song_state", S_HOLD);
        tick(5);
        chk("hold_song_stay", 1'b0, 3'd0, 3'd1, 1'b0);
        is_playing = 1'b1;
        tick(1);
        chk("resume_no_strobe", 1'b0, 3'd0, 3'd1, 1'b0);
        chk_state("resume_state", S_RUN);
        tick(8);
        chk("resume_rise", 1'b1, 3'd0, 3'd1, 1'b0);
        tick(312);

`ifdef TONE_LOOP_EN
        chk("loop_wrap", 1'b0, 3'd0, 3'd1, 1'b1);
        chk_state("loop_state", S_RUN);
        tick(8);
        chk("loop_rise", 1'b1, 3'd0, 3'd1, 1'b0);
`else
        chk("done_enter", 1'b0, 3'd7, 3'd0, 1'b0);
        chk_state("done_state", S_DONE);
        tick(20);
        chk("done_hold", 1'b0, 3'd7, 3'd0, 1'b0);
        song = 2'd2;
        tick(1);
        chk("done_restart", 1'b0, 3'd0, 3'd1, 1'b1);
        chk_state("done_restart_state", S_RUN);
        is_playing = 1'b0;
        tick(1);
        chk_state("pause3_state", S_HOLD);
        is_playing = 1'b1;
        tick(1);
        tick(320);
        chk("done2_enter", 1'b0, 3'd7, 3'd0, 1'b0);
        chk_state("done2_state", S_DONE);
        is_playing = 1'b0;
        tick(1);
        chk("done_to_idle", 1'b0, 3'd0, 3'd1, 1'b0);
        chk_state("done_to_idle_state", S_IDLE);
        is_playing = 1'b1;
        tick(1);
        chk("idle_to_run", 1'b0, 3'd0, 3'd1, 1'b1);
`endif

        // Asynchronous reset in the middle of a cycle.
        tick(13);
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset", 1'b0, 3'd0, 3'd1, 1'b0);
        chk_state("async_reset_state", S_IDLE);
        tick(2);
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
